// File: rtl/rggen_rtl_pkg.sv
// rtl/rggen_rtl_pkg.sv - shared rggen bus types and bus arbiter state encoding
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic [1:0] {
        RGGEN_ARB_IDLE    = 2'b00,
        RGGEN_ARB_BUSY    = 2'b01,
        RGGEN_ARB_RESPOND = 2'b10
    } rggen_bus_arbiter_state;

    // Index width that stays legal for a single-entry vector.
    function automatic int rggen_index_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rggen_round_robin_arbiter.sv
// rtl/rggen_round_robin_arbiter.sv - combinational round-robin pick starting after the last grant
module rggen_round_robin_arbiter
    import rggen_rtl_pkg::*;
#(
    parameter int HOSTS       = 2,
    parameter int INDEX_WIDTH = rggen_index_width(HOSTS)
) (
    input  logic [HOSTS-1:0]       i_request,
    input  logic [INDEX_WIDTH-1:0] i_last,
    output logic [HOSTS-1:0]       o_grant,
    output logic [INDEX_WIDTH-1:0] o_index
);

    logic                   found;
    logic [INDEX_WIDTH-1:0] idx;

    // Scan last+1 .. last (mod HOSTS); the previous winner is checked last.
    always_comb begin
        o_grant = '0;
        o_index = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= HOSTS; i++) begin
            idx = INDEX_WIDTH'((int'(i_last) + i) % HOSTS);
            if (!found && i_request[idx]) begin
                found        = 1'b1;
                o_grant[idx] = 1'b1;
                o_index      = idx;
            end
        end
    end

endmodule

// File: rtl/rggen_bus_arbiter.sv
// rtl/rggen_bus_arbiter.sv - round-robin sharing of one rggen register bus between several hosts
module rggen_bus_arbiter
    import rggen_rtl_pkg::*;
#(
    parameter int                   HOSTS         = 2,
    parameter int                   ADDRESS_WIDTH = 8,
    parameter int                   BUS_WIDTH     = 32,
    parameter int                   TIMEOUT       = 0,
    parameter rggen_status          ERROR_STATUS  = RGGEN_SLAVE_ERROR,
    parameter logic [BUS_WIDTH-1:0] ERROR_DATA    = '0
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [HOSTS-1:0]                 i_host_valid,
    input  logic [HOSTS*ADDRESS_WIDTH-1:0]   i_host_address,
    input  logic [HOSTS-1:0]                 i_host_write,
    input  logic [HOSTS*BUS_WIDTH-1:0]       i_host_write_data,
    input  logic [HOSTS*BUS_WIDTH/8-1:0]     i_host_strobe,
    output logic [HOSTS-1:0]                 o_host_ready,
    output logic [1:0]                       o_host_status,
    output logic [BUS_WIDTH-1:0]             o_host_read_data,
    output logic                             o_bus_valid,
    output logic [ADDRESS_WIDTH-1:0]         o_bus_address,
    output logic                             o_bus_write,
    output logic [BUS_WIDTH-1:0]             o_bus_write_data,
    output logic [BUS_WIDTH/8-1:0]           o_bus_strobe,
    input  logic                             i_bus_ready,
    input  logic [1:0]                       i_bus_status,
    input  logic [BUS_WIDTH-1:0]             i_bus_read_data
);

    localparam int IW = rggen_index_width(HOSTS);
    localparam int SW = BUS_WIDTH / 8;

    rggen_bus_arbiter_state state_q, state_d;
    logic [IW-1:0]            last_q, last_d;
    logic [HOSTS-1:0]         grant_q, grant_d;
    logic                     bus_valid_q, bus_valid_d;
    logic [ADDRESS_WIDTH-1:0] bus_address_q, bus_address_d;
    logic                     bus_write_q, bus_write_d;
    logic [BUS_WIDTH-1:0]     bus_write_data_q, bus_write_data_d;
    logic [SW-1:0]            bus_strobe_q, bus_strobe_d;
    logic [HOSTS-1:0]         host_ready_q, host_ready_d;
    rggen_status              status_q, status_d;
    logic [BUS_WIDTH-1:0]     read_data_q, read_data_d;
    logic [HOSTS-1:0]         rr_grant;
    logic [IW-1:0]            rr_index;
    logic                     timeout_hit;

    rggen_round_robin_arbiter #(
        .HOSTS       (HOSTS),
        .INDEX_WIDTH (IW)
    ) u_rr (
        .i_request (i_host_valid),
        .i_last    (last_q),
        .o_grant   (rr_grant),
        .o_index   (rr_index)
    );

    always_comb begin
        state_d          = state_q;
        last_d           = last_q;
        grant_d          = grant_q;
        bus_valid_d      = bus_valid_q;
        bus_address_d    = bus_address_q;
        bus_write_d      = bus_write_q;
        bus_write_data_d = bus_write_data_q;
        bus_strobe_d     = bus_strobe_q;
        host_ready_d     = '0;
        status_d         = status_q;
        read_data_d      = read_data_q;
        case (state_q)
            RGGEN_ARB_IDLE: begin
                if (|i_host_valid) begin
                    last_d           = rr_index;
                    grant_d          = rr_grant;
                    bus_valid_d      = 1'b1;
                    bus_address_d    = i_host_address[rr_index*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    bus_write_d      = i_host_write[rr_index];
                    bus_write_data_d = i_host_write_data[rr_index*BUS_WIDTH +: BUS_WIDTH];
                    bus_strobe_d     = i_host_strobe[rr_index*SW +: SW];
                    state_d          = RGGEN_ARB_BUSY;
                end
            end
            RGGEN_ARB_BUSY: begin
                // A real ack beats a timeout landing in the same cycle.
                if (i_bus_ready) begin
                    status_d     = rggen_status'(i_bus_status);
                    read_data_d  = i_bus_read_data;
                    bus_valid_d  = 1'b0;
                    host_ready_d = grant_q;
                    state_d      = RGGEN_ARB_RESPOND;
                end else if (timeout_hit) begin
                    status_d     = ERROR_STATUS;
                    read_data_d  = ERROR_DATA;
                    bus_valid_d  = 1'b0;
                    host_ready_d = grant_q;
                    state_d      = RGGEN_ARB_RESPOND;
                end
            end
            RGGEN_ARB_RESPOND: begin
                state_d = RGGEN_ARB_IDLE;
            end
            default: begin
                state_d = RGGEN_ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q          <= RGGEN_ARB_IDLE;
            last_q           <= IW'(HOSTS - 1);
            grant_q          <= '0;
            bus_valid_q      <= 1'b0;
            bus_address_q    <= '0;
            bus_write_q      <= 1'b0;
            bus_write_data_q <= '0;
            bus_strobe_q     <= '0;
            host_ready_q     <= '0;
            status_q         <= RGGEN_OKAY;
            read_data_q      <= '0;
        end else begin
            state_q          <= state_d;
            last_q           <= last_d;
            grant_q          <= grant_d;
            bus_valid_q      <= bus_valid_d;
            bus_address_q    <= bus_address_d;
            bus_write_q      <= bus_write_d;
            bus_write_data_q <= bus_write_data_d;
            bus_strobe_q     <= bus_strobe_d;
            host_ready_q     <= host_ready_d;
            status_q         <= status_d;
            read_data_q      <= read_data_d;
        end
    end

    if (TIMEOUT > 0) begin : g_timer
        localparam int TW = $clog2(TIMEOUT + 1);
        logic [TW-1:0] timer_q, timer_d;

        always_comb begin
            timer_d = '0;
            if ((state_q == RGGEN_ARB_BUSY) && (state_d == RGGEN_ARB_BUSY)) begin
                timer_d = timer_q + 1'b1;
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_d;
            end
        end

        assign timeout_hit = (state_q == RGGEN_ARB_BUSY) && (timer_q == TW'(TIMEOUT - 1));
    end else begin : g_no_timer
        assign timeout_hit = 1'b0;
    end

    assign o_host_ready     = host_ready_q;
    assign o_host_status    = status_q;
    assign o_host_read_data = read_data_q;
    assign o_bus_valid      = bus_valid_q;
    assign o_bus_address    = bus_address_q;
    assign o_bus_write      = bus_write_q;
    assign o_bus_write_data = bus_write_data_q;
    assign o_bus_strobe     = bus_strobe_q;

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// tb/tb_rggen_bus_arbiter.sv - randomized self-checking bench for rggen_bus_arbiter
module tb_rggen_bus_arbiter;
    import rggen_rtl_pkg::*;

    localparam int H   = 3;
    localparam int AW  = 8;
    localparam int BW  = 32;
    localparam int TO  = 4;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [H-1:0]    i_host_valid = '0;
    logic [H*AW-1:0] i_host_address = '0;
    logic [H-1:0]    i_host_write = '0;
    logic [H*BW-1:0] i_host_write_data = '0;
    logic [H*4-1:0]  i_host_strobe = '0;
    logic [H-1:0]    o_host_ready;
    logic [1:0]      o_host_status;
    logic [BW-1:0]   o_host_read_data;
    logic            o_bus_valid;
    logic [AW-1:0]   o_bus_address;
    logic            o_bus_write;
    logic [BW-1:0]   o_bus_write_data;
    logic [3:0]      o_bus_strobe;
    logic            i_bus_ready = 1'b0;
    logic [1:0]      i_bus_status = '0;
    logic [BW-1:0]   i_bus_read_data = '0;

    rggen_bus_arbiter #(
        .HOSTS         (H),
        .ADDRESS_WIDTH (AW),
        .BUS_WIDTH     (BW),
        .TIMEOUT       (TO),
        .ERROR_STATUS  (RGGEN_SLAVE_ERROR),
        .ERROR_DATA    (ERR_DATA)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_host_valid      (i_host_valid),
        .i_host_address    (i_host_address),
        .i_host_write      (i_host_write),
        .i_host_write_data (i_host_write_data),
        .i_host_strobe     (i_host_strobe),
        .o_host_ready      (o_host_ready),
        .o_host_status     (o_host_status),
        .o_host_read_data  (o_host_read_data),
        .o_bus_valid       (o_bus_valid),
        .o_bus_address     (o_bus_address),
        .o_bus_write       (o_bus_write),
        .o_bus_write_data  (o_bus_write_data),
        .o_bus_strobe      (o_bus_strobe),
        .i_bus_ready       (i_bus_ready),
        .i_bus_status      (i_bus_status),
        .i_bus_read_data   (i_bus_read_data)
    );

    always #5 clk = ~clk;

    // Host-side view of every requester plus the model's round-robin pointer.
    logic [H-1:0] h_valid = '0;
    logic [AW-1:0] h_addr [H];
    logic          h_write [H];
    logic [BW-1:0] h_wdata [H];
    logic [3:0]    h_strb [H];
    int m_last = H - 1;
    int dut_acks [H];
    int total = 0;
    int bad = 0;

    function automatic int rr_pick(input logic [H-1:0] m, input int last);
        for (int i = 1; i <= H; i++) begin
            int idx;
            idx = (last + i) % H;
            if (m[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        for (int h = 0; h < H; h++) begin
            i_host_valid[h]              = h_valid[h];
            i_host_address[h*AW +: AW]   = h_addr[h];
            i_host_write[h]              = h_write[h];
            i_host_write_data[h*BW +: BW] = h_wdata[h];
            i_host_strobe[h*4 +: 4]      = h_strb[h];
        end
    endtask

    task automatic new_req(input int h);
        h_addr[h]  = 8'($urandom);
        h_write[h] = 1'($urandom);
        h_wdata[h] = $urandom;
        h_strb[h]  = 4'($urandom);
        h_valid[h] = 1'b1;
        drive();
    endtask

    task automatic drop(input int h);
        h_valid[h] = 1'b0;
        drive();
    endtask

    // One access from an IDLE cycle: bus acks after d wait cycles (d >= TO never acks).
    task automatic txn(input int d, input int force_status, output int w);
        logic [1:0]  es;
        logic [31:0] ed;
        bit          acked;
        w = rr_pick(h_valid, m_last);
        step();
        total++;
        if (o_bus_valid !== 1'b1 || o_bus_address !== h_addr[w] || o_bus_write !== h_write[w] ||
            o_bus_write_data !== h_wdata[w] || o_bus_strobe !== h_strb[w]) begin
            bad++;
            $display("FAIL bus_request host=%0d got v=%b a=%h w=%b d=%h s=%h exp v=1 a=%h w=%b d=%h s=%h",
                     w, o_bus_valid, o_bus_address, o_bus_write, o_bus_write_data, o_bus_strobe,
                     h_addr[w], h_write[w], h_wdata[w], h_strb[w]);
        end
        total++;
        if (o_host_ready !== '0) begin
            bad++;
            $display("FAIL early_ready got=%b exp=000", o_host_ready);
        end
        acked = 1'b0;
        es = '0;
        ed = '0;
        for (int c = 0; c < TO && !acked; c++) begin
            if (c > 0) begin
                total++;
                if (o_bus_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL bus_valid_hold cycle=%0d got=%b exp=1", c, o_bus_valid);
                end
            end
            if (c == d) begin
                acked = 1'b1;
                es = (force_status >= 0) ? 2'(force_status) : 2'($urandom);
                ed = $urandom;
                i_bus_ready = 1'b1;
                i_bus_status = es;
                i_bus_read_data = ed;
            end else begin
                i_bus_ready = 1'b0;
                i_bus_status = 2'($urandom);
                i_bus_read_data = $urandom;
            end
            step();
        end
        if (!acked) begin
            es = 2'b10;
            ed = ERR_DATA;
        end
        i_bus_ready = 1'($urandom);
        total++;
        if (o_host_ready !== H'(1 << w) || o_host_status !== es || o_host_read_data !== ed ||
            o_bus_valid !== 1'b0) begin
            bad++;
            $display("FAIL respond host=%0d got r=%b st=%h rd=%h v=%b exp r=%b st=%h rd=%h v=0",
                     w, o_host_ready, o_host_status, o_host_read_data, o_bus_valid,
                     H'(1 << w), es, ed);
        end
        for (int h = 0; h < H; h++) if (o_host_ready[h]) dut_acks[h]++;
        m_last = w;
        step();
        i_bus_ready = 1'b0;
        total++;
        if (o_host_ready !== '0 || o_bus_valid !== 1'b0 || o_host_status !== es ||
            o_host_read_data !== ed) begin
            bad++;
            $display("FAIL idle_after host=%0d got r=%b v=%b st=%h rd=%h exp r=000 v=0 st=%h rd=%h",
                     w, o_host_ready, o_bus_valid, o_host_status, o_host_read_data, es, ed);
        end
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if (o_bus_valid !== 1'b0 || o_bus_address !== '0 || o_bus_write !== 1'b0 ||
            o_bus_write_data !== '0 || o_bus_strobe !== '0 || o_host_ready !== '0 ||
            o_host_status !== '0 || o_host_read_data !== '0) begin
            bad++;
            $display("FAIL %s got v=%b a=%h w=%b d=%h s=%h r=%b st=%h rd=%h exp all zero", name,
                     o_bus_valid, o_bus_address, o_bus_write, o_bus_write_data, o_bus_strobe,
                     o_host_ready, o_host_status, o_host_read_data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        check_all_zero("reset_state");
        rst = 1'b0;
        m_last = H - 1;
    endtask

    task automatic test_single_write();
        int w;
        h_addr[0]  = 8'h10;
        h_write[0] = 1'b1;
        h_wdata[0] = 32'hA5A5_A5A5;
        h_strb[0]  = 4'hF;
        h_valid[0] = 1'b1;
        drive();
        txn(1, 0, w);
        drop(0);
    endtask

    task automatic test_alternate();
        int w;
        int a0, a1;
        a0 = dut_acks[0];
        a1 = dut_acks[1];
        new_req(0);
        new_req(1);
        for (int n = 0; n < 6; n++) begin
            txn(0, -1, w);
            new_req(w);
        end
        total++;
        if (dut_acks[0] - a0 !== 3 || dut_acks[1] - a1 !== 3) begin
            bad++;
            $display("FAIL alternate_share got h0=%0d h1=%0d exp 3 each",
                     dut_acks[0] - a0, dut_acks[1] - a1);
        end
        drop(0);
        drop(1);
    endtask

    task automatic test_hosts_1_2();
        int w;
        new_req(2);
        txn(0, -1, w);
        new_req(1);
        new_req(2);
        txn(1, -1, w);
        drop(w);
        txn(0, -1, w);
        drop(w);
        drop(1);
        drop(2);
    endtask

    task automatic test_timeout();
        int w;
        new_req(1);
        txn(100, -1, w);
        drop(1);
        new_req(0);
        txn(2, -1, w);
        drop(0);
    endtask

    task automatic test_tie();
        int w;
        new_req(2);
        txn(TO - 1, -1, w);
        drop(2);
    endtask

    task automatic test_random();
        int w;
        for (int n = 0; n < 24; n++) begin
            for (int h = 0; h < H; h++) if (!h_valid[h] && $urandom_range(0, 1) == 1) new_req(h);
            if (h_valid == '0) new_req(int'($urandom_range(0, H - 1)));
            txn(int'($urandom_range(0, 5)), -1, w);
            if ($urandom_range(0, 1) == 1) new_req(w);
            else drop(w);
        end
        for (int h = 0; h < H; h++) drop(h);
    endtask

    task automatic test_reset_mid();
        int w;
        new_req(0);
        new_req(1);
        w = rr_pick(h_valid, m_last);
        step();
        total++;
        if (o_bus_valid !== 1'b1 || o_bus_address !== h_addr[w]) begin
            bad++;
            $display("FAIL pre_reset_busy got v=%b a=%h exp v=1 a=%h", o_bus_valid, o_bus_address,
                     h_addr[w]);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("reset_mid_access");
        m_last = H - 1;
        txn(0, -1, w);
        total++;
        if (dut_acks[0] < 1 || o_host_ready !== '0) begin
            bad++;
            $display("FAIL reissue_priority got acks0=%0d r=%b", dut_acks[0], o_host_ready);
        end
        drop(0);
        drop(1);
    endtask

    initial begin
        for (int h = 0; h < H; h++) begin
            h_addr[h] = '0;
            h_write[h] = 1'b0;
            h_wdata[h] = '0;
            h_strb[h] = '0;
            dut_acks[h] = 0;
        end
        drive();
        test_reset();
        test_single_write();
        test_alternate();
        test_hosts_1_2();
        test_timeout();
        test_tie();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
